// File: rtl/pc_voter_pkg.sv
// Shared types and constants for the TMR program-counter voter.
package pc_voter_pkg;

   typedef enum logic [1:0] {
      NORMAL   = 2'd0,
      DEGRADED = 2'd1,
      SAFE     = 2'd2
   } voter_fsm_e;

   localparam int CORE_A = 0;
   localparam int CORE_B = 1;
   localparam int CORE_C = 2;

   localparam int VS_AB = 0;
   localparam int VS_BC = 1;
   localparam int VS_AC = 2;

   localparam int                CNT_W   = 4;
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

endpackage

// File: rtl/pc_fault_counter.sv
// Saturating event counter; hit_o flags the increment that brings it to LIMIT.
module pc_fault_counter
   import pc_voter_pkg::*;
#(
   parameter int LIMIT = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic hit_o
);

   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (en_i) begin
         if (clr_i)
            count_d = '0;
         else if (inc_i && count_q != CNT_MAX)
            count_d = count_q + 1'b1;
      end
   end

   // Combinational so the owner can escalate on the same edge the count lands on LIMIT.
   assign hit_o = en_i && inc_i && !clr_i && (count_q >= LIMIT_M1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count_q <= '0;
      else
         count_q <= count_d;
   end

endmodule

// File: rtl/pc_majority_voter.sv
// Triple-redundant PC voter with per-core fault exclusion and latched safe-halt.
module pc_majority_voter
   import pc_voter_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter int               FAULT_LIMIT = 3,
   parameter logic [WIDTH-1:0] RESET_PC    = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] pc_a,
   input  logic [WIDTH-1:0] pc_b,
   input  logic [WIDTH-1:0] pc_c,
   output logic [WIDTH-1:0] pc_voted,
   output logic [2:0]       voter_state,
   output logic [2:0]       mismatch,
   output logic [2:0]       core_fault,
   output logic             halt
);

   // Assert asynchronously, release two clocks after rst_n rises.
   logic [1:0] rst_sync_q;
   logic       srst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rst_sync_q <= '0;
      else
         rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign srst_n = rst_sync_q[1];

   voter_fsm_e       state_q;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [2:0]       vs_q, mm_q, fault_q;
   logic             halt_q;

   logic [2:0] pair_eq, live_pair, vote_vs, agree, outlier, core_hit;
   logic       resolved, active, normal, single_pair, unres_hit;

   assign pair_eq[VS_AB] = (pc_a == pc_b);
   assign pair_eq[VS_BC] = (pc_b == pc_c);
   assign pair_eq[VS_AC] = (pc_a == pc_c);

   // A pair only counts while neither of its cores has been excluded.
   assign live_pair[VS_AB] = ~fault_q[CORE_A] & ~fault_q[CORE_B];
   assign live_pair[VS_BC] = ~fault_q[CORE_B] & ~fault_q[CORE_C];
   assign live_pair[VS_AC] = ~fault_q[CORE_A] & ~fault_q[CORE_C];

   assign vote_vs  = pair_eq & live_pair;
   assign resolved = |vote_vs;
   assign active   = in_valid && (state_q != SAFE);
   assign normal   = (state_q == NORMAL);

   assign single_pair     = $onehot(pair_eq);
   assign outlier[CORE_A] = single_pair & pair_eq[VS_BC];
   assign outlier[CORE_B] = single_pair & pair_eq[VS_AC];
   assign outlier[CORE_C] = single_pair & pair_eq[VS_AB];

   assign agree[CORE_A] = pair_eq[VS_AB] | pair_eq[VS_AC];
   assign agree[CORE_B] = pair_eq[VS_AB] | pair_eq[VS_BC];
   assign agree[CORE_C] = pair_eq[VS_BC] | pair_eq[VS_AC];

   always_comb begin
      pc_d = pc_q;
      if (vote_vs[VS_AB] || vote_vs[VS_AC])
         pc_d = pc_a;
      else if (vote_vs[VS_BC])
         pc_d = pc_b;
   end

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_core_cnt
         pc_fault_counter #(.LIMIT(FAULT_LIMIT)) u_cnt (
            .clk   (clk),
            .rst_n (srst_n),
            .en_i  (active && normal),
            .inc_i (outlier[gi]),
            .clr_i (agree[gi]),
            .hit_o (core_hit[gi])
         );
      end
   endgenerate

   pc_fault_counter #(.LIMIT(FAULT_LIMIT)) u_unres_cnt (
      .clk   (clk),
      .rst_n (srst_n),
      .en_i  (active),
      .inc_i (!resolved),
      .clr_i (resolved),
      .hit_o (unres_hit)
   );

   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         state_q <= NORMAL;
         pc_q    <= RESET_PC;
         vs_q    <= 3'b111;
         mm_q    <= '0;
         fault_q <= '0;
         halt_q  <= 1'b0;
      end else begin
         mm_q <= '0;
         if (active) begin
            pc_q <= pc_d;
            vs_q <= vote_vs;
            if (normal) begin
               mm_q    <= outlier;
               fault_q <= fault_q | core_hit;
               if (|core_hit)
                  state_q <= DEGRADED;
            end
            if (unres_hit) begin
               state_q <= SAFE;
               halt_q  <= 1'b1;
               vs_q    <= '0;
            end
         end
      end
   end

   assign pc_voted    = pc_q;
   assign voter_state = vs_q;
   assign mismatch    = mm_q;
   assign core_fault  = fault_q;
   assign halt        = halt_q;

endmodule

// File: tb/tb_pc_majority_voter.sv
// Directed bench for pc_majority_voter with a per-cycle behavioural reference.
module tb_pc_majority_voter;

   localparam int LIM = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] pc_a = '0, pc_b = '0, pc_c = '0;
   logic [31:0] pc_voted;
   logic [2:0]  voter_state, mismatch, core_fault;
   logic        halt;

   pc_majority_voter #(.WIDTH(32), .FAULT_LIMIT(LIM), .RESET_PC(32'h0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .pc_a        (pc_a),
      .pc_b        (pc_b),
      .pc_c        (pc_c),
      .pc_voted    (pc_voted),
      .voter_state (voter_state),
      .mismatch    (mismatch),
      .core_fault  (core_fault),
      .halt        (halt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 normal, 1 degraded, 2 safe.
   int          m_mode;
   int          m_cnt[3];
   int          m_unres;
   logic [2:0]  m_fault, m_vs, m_mm;
   logic [31:0] m_pc;
   logic        m_halt;

   task automatic m_reset();
      m_mode = 0; m_unres = 0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_fault = '0; m_vs = 3'b111; m_mm = '0; m_pc = '0; m_halt = 1'b0;
   endtask

   task automatic m_step();
      logic [31:0] p[3];
      int pi[3], pj[3], agree[3];
      int npairs;
      bit found;
      p[0] = pc_a; p[1] = pc_b; p[2] = pc_c;
      pi = '{0, 1, 0};
      pj = '{1, 2, 2};
      agree = '{0, 0, 0};
      npairs = 0;
      m_vs = '0;
      for (int k = 0; k < 3; k++) begin
         if (!m_fault[pi[k]] && !m_fault[pj[k]] && p[pi[k]] == p[pj[k]]) begin
            m_vs[k] = 1'b1;
            npairs++;
            agree[pi[k]]++;
            agree[pj[k]]++;
         end
      end
      if (npairs > 0) begin
         m_unres = 0;
         found = 1'b0;
         for (int i = 0; i < 3; i++)
            if (!found && agree[i] > 0) begin m_pc = p[i]; found = 1'b1; end
      end else begin
         m_unres = (m_unres < 15) ? m_unres + 1 : 15;
      end
      if (m_mode == 0) begin
         for (int i = 0; i < 3; i++) begin
            if (agree[i] > 0)
               m_cnt[i] = 0;
            else if (npairs == 1) begin
               m_cnt[i] = (m_cnt[i] < 15) ? m_cnt[i] + 1 : 15;
               m_mm[i] = 1'b1;
               if (m_cnt[i] >= LIM) begin m_fault[i] = 1'b1; m_mode = 1; end
            end
         end
      end
      if (m_unres >= LIM) begin m_mode = 2; m_halt = 1'b1; m_vs = '0; end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         m_reset();
      else begin
         m_mm = '0;
         if (in_valid && m_mode != 2) m_step();
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_pc_voted", pc_voted, m_pc);
         check("model_voter_state", {29'b0, voter_state}, {29'b0, m_vs});
         check("model_mismatch", {29'b0, mismatch}, {29'b0, m_mm});
         check("model_core_fault", {29'b0, core_fault}, {29'b0, m_fault});
         check("model_halt", {31'b0, halt}, {31'b0, m_halt});
      end
   end

   task automatic vote(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      pc_a = a; pc_b = b; pc_c = c; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_pc"}, pc_voted, 32'h0);
      check({tag, "_vs"}, {29'b0, voter_state}, 32'd7);
      check({tag, "_flags"}, {25'b0, mismatch, core_fault, halt}, 32'd0);
   endtask

   // Async reset pulse placed between clock edges; outputs must drop at once.
   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      #1 check_reset_values("rst_immediate");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk_en = 1'b1;

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_reset_values("idle");
      end

      vote(32'h100, 32'h100, 32'h100);
      check("agree_pc", pc_voted, 32'h100);
      check("agree_vs", {29'b0, voter_state}, 32'd7);
      check("agree_mm", {29'b0, mismatch}, 32'd0);

      for (int i = 0; i < 3; i++) begin
         vote(32'h104, 32'h104, 32'h200);
         check("c_out_vs", {29'b0, voter_state}, 32'd1);
         check("c_out_mm", {29'b0, mismatch}, 32'd4);
         check("c_out_fault", {29'b0, core_fault}, (i == 2) ? 32'd4 : 32'd0);
      end
      check("c_out_pc", pc_voted, 32'h104);

      vote(32'h108, 32'h108, 32'h108);
      check("degr_ignore_vs", {29'b0, voter_state}, 32'd1);
      check("degr_ignore_pc", pc_voted, 32'h108);
      check("degr_ignore_mm", {29'b0, mismatch}, 32'd0);

      pulse_reset();
      vote(32'h110, 32'h110, 32'h300);
      vote(32'h110, 32'h110, 32'h300);
      vote(32'h114, 32'h114, 32'h114);
      vote(32'h118, 32'h118, 32'h300);
      vote(32'h118, 32'h118, 32'h300);
      check("cleared_cnt_fault", {29'b0, core_fault}, 32'd0);
      check("cleared_cnt_mm", {29'b0, mismatch}, 32'd4);

      pulse_reset();
      for (int i = 0; i < 3; i++) vote(32'h120, 32'h120, 32'h400);
      check("to_degr_fault", {29'b0, core_fault}, 32'd4);
      for (int i = 0; i < 3; i++) begin
         vote(32'h10, 32'h14, 32'h999);
         check("degr_split_vs", {29'b0, voter_state}, 32'd0);
         check("degr_split_pc", pc_voted, 32'h120);
         check("degr_split_halt", {31'b0, halt}, (i == 2) ? 32'd1 : 32'd0);
      end
      vote(32'h20, 32'h20, 32'h20);
      check("safe_pc", pc_voted, 32'h120);
      check("safe_vs", {29'b0, voter_state}, 32'd0);
      check("safe_halt", {31'b0, halt}, 32'd1);

      pulse_reset();
      for (int i = 0; i < 3; i++) vote(32'h120, 32'h120, 32'h400);
      vote(32'h10, 32'h14, 32'h0);
      pulse_reset();
      vote(32'h30, 32'h30, 32'h30);
      check("post_rst_vs", {29'b0, voter_state}, 32'd7);
      check("post_rst_pc", pc_voted, 32'h30);

      vote(32'h1, 32'h2, 32'h3);
      check("unres1_vs", {29'b0, voter_state}, 32'd0);
      check("unres1_pc", pc_voted, 32'h30);
      vote(32'h4, 32'h5, 32'h6);
      check("unres2_vs", {29'b0, voter_state}, 32'd0);
      vote(32'h7, 32'h7, 32'h9);
      check("resolve_vs", {29'b0, voter_state}, 32'd1);
      check("resolve_pc", pc_voted, 32'h7);
      vote(32'h1, 32'h2, 32'h3);
      vote(32'h4, 32'h5, 32'h6);
      check("unres_cleared_halt", {31'b0, halt}, 32'd0);
      vote(32'h1, 32'h2, 32'h3);
      check("unres_limit_halt", {31'b0, halt}, 32'd1);
      check("unres_limit_pc", pc_voted, 32'h7);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
